// File: rtl/m2_block_writer.sv
// rtl/m2_block_writer.sv - writes one clipped, packed 8x8 IDCT block into the SRAM Y/U/V segments (option macro: M2_WRITE_CLIP_EN)
module m2_block_writer #(
    parameter logic [17:0] Y_BASE = 18'd0,
    parameter logic [17:0] U_BASE = 18'd38400,
    parameter logic [17:0] V_BASE = 18'd57600
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    output logic [5:0]  DP_address_a,
    output logic [5:0]  DP_address_b,
    input  logic [31:0] DP_read_data_a,
    input  logic [31:0] DP_read_data_b,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Done,
    output logic        All_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [11:0] LAST_Y_BLK = 12'd1199;
    localparam logic [11:0] LAST_U_BLK = 12'd1799;
    localparam logic [11:0] LAST_BLK   = 12'd2399;

    state_t      state_q;
    logic [4:0]  k_q;            // word being written in S_WRITE, row-major r*4+c
    logic [11:0] blk_q;          // block number across the whole image
    logic [5:0]  bc_q;           // block column inside the current segment
    logic        chroma_q;       // 1 once in U/V: 20 blocks per row, stride 80
    logic [17:0] blk_base_q;     // word address of row 0, column 0 of this block

    logic        we_n_q;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic [5:0]  dpa_q;
    logic [5:0]  dpb_q;
    logic        done_q;
    logic        all_done_q;

    logic [17:0] row_ext;
    logic [17:0] row_off_d;
    logic [17:0] addr_d;
    logic [15:0] pair_d;
    logic [4:0]  k_plus2;
    logic        last_col;
    logic [17:0] next_base_d;
    logic [5:0]  next_bc_d;
    logic        next_chroma_d;

`ifdef M2_WRITE_CLIP_EN
    // Saturate a signed IDCT sample into 0..255.
    function automatic logic [7:0] to_byte(input logic [31:0] v);
        if (v[31])
            return 8'd0;
        else if (|v[30:8])
            return 8'd255;
        else
            return v[7:0];
    endfunction
`else
    // Plain truncation: only the low byte of each sample is stored.
    function automatic logic [7:0] to_byte(input logic [31:0] v);
        return v[7:0];
    endfunction

    logic unused_hi;
    assign unused_hi = ^{DP_read_data_a[31:8], DP_read_data_b[31:8]};
`endif

    // Current write address and packed sample pair, plus the DP index two words ahead.
    always_comb begin
        row_ext = {15'd0, k_q[4:2]};
        if (chroma_q)
            row_off_d = (row_ext << 6) + (row_ext << 4);
        else
            row_off_d = (row_ext << 7) + (row_ext << 5);
        addr_d  = blk_base_q + row_off_d + {16'd0, k_q[1:0]};
        pair_d  = {to_byte(DP_read_data_a), to_byte(DP_read_data_b)};
        k_plus2 = k_q + 5'd2;
    end

    // Position of the next block: step one block right, wrap to the next block-row
    // (8 pixel rows down), or jump to the start of the next segment.
    always_comb begin
        last_col      = chroma_q ? (bc_q == 6'd19) : (bc_q == 6'd39);
        next_bc_d     = last_col ? 6'd0 : bc_q + 6'd1;
        next_chroma_d = chroma_q;
        if (blk_q == LAST_Y_BLK) begin
            next_base_d   = U_BASE;
            next_bc_d     = 6'd0;
            next_chroma_d = 1'b1;
        end else if (blk_q == LAST_U_BLK) begin
            next_base_d   = V_BASE;
            next_bc_d     = 6'd0;
        end else if (last_col) begin
            next_base_d = blk_base_q + 18'd4 + (chroma_q ? 18'd560 : 18'd1120);
        end else begin
            next_base_d = blk_base_q + 18'd4;
        end
    end

    // Block FSM with all outputs registered; reset aborts any block in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            k_q        <= 5'd0;
            blk_q      <= 12'd0;
            bc_q       <= 6'd0;
            chroma_q   <= 1'b0;
            blk_base_q <= Y_BASE;
            we_n_q     <= 1'b1;
            addr_q     <= 18'd0;
            wdata_q    <= 16'd0;
            dpa_q      <= 6'd0;
            dpb_q      <= 6'd1;
            done_q     <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_n_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    k_q   <= 5'd0;
                    dpa_q <= 6'd0;
                    dpb_q <= 6'd1;
                    if (Start && !all_done_q)
                        state_q <= S_FILL;
                end
                S_FILL: begin
                    dpa_q   <= 6'd2;
                    dpb_q   <= 6'd3;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    we_n_q  <= 1'b0;
                    addr_q  <= addr_d;
                    wdata_q <= pair_d;
                    dpa_q   <= {k_plus2, 1'b0};
                    dpb_q   <= {k_plus2, 1'b1};
                    k_q     <= k_q + 5'd1;
                    if (k_q == 5'd31)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    dpa_q   <= 6'd0;
                    dpb_q   <= 6'd1;
                    k_q     <= 5'd0;
                    state_q <= S_IDLE;
                    if (blk_q == LAST_BLK) begin
                        all_done_q <= 1'b1;
                    end else begin
                        blk_q      <= blk_q + 12'd1;
                        bc_q       <= next_bc_d;
                        chroma_q   <= next_chroma_d;
                        blk_base_q <= next_base_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DP_address_a    = dpa_q;
    assign DP_address_b    = dpb_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Done            = done_q;
    assign All_done        = all_done_q;

endmodule

// File: tb/tb_m2_block_writer.sv
// tb/tb_m2_block_writer.sv - self-checking bench for m2_block_writer against a block/address reference model
module tb_m2_block_writer;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Start = 1'b0;
    logic [5:0]  DP_address_a;
    logic [5:0]  DP_address_b;
    logic [31:0] DP_read_data_a = 32'd0;
    logic [31:0] DP_read_data_b = 32'd0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        Done;
    logic        All_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem [64];

    int wr_addr [$];
    int wr_data [$];
    int wr_cyc  [$];
    int done_cyc [$];
    int done_ad  [$];

    m2_block_writer dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start),
        .DP_address_a(DP_address_a), .DP_address_b(DP_address_b),
        .DP_read_data_a(DP_read_data_a), .DP_read_data_b(DP_read_data_b),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .Done(Done), .All_done(All_done)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        DP_read_data_a <= mem[DP_address_a];
        DP_read_data_b <= mem[DP_address_b];
    end

    always @(negedge Clock) begin
        if (SRAM_we_n === 1'b0) begin
            wr_addr.push_back(int'(SRAM_address));
            wr_data.push_back(int'(SRAM_write_data));
            wr_cyc.push_back(cyc);
        end
        if (Done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_ad.push_back(int'(All_done));
        end
    end

    function automatic int exp_addr(input int blk, input int k);
        int base, cols, off, br, bc;
        if (blk < 1200) begin base = 0;     cols = 40; off = blk;        end
        else if (blk < 1800) begin base = 38400; cols = 20; off = blk - 1200; end
        else begin base = 57600; cols = 20; off = blk - 1800; end
        br = off / cols;
        bc = off % cols;
        return base + (br * 8 + k / 4) * (cols * 4) + bc * 4 + k % 4;
    endfunction

    function automatic int exp_byte(input int v);
`ifdef M2_WRITE_CLIP_EN
        if (v < 0) return 0;
        if (v > 255) return 255;
`endif
        return v & 255;
    endfunction

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc.delete(); done_ad.delete();
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 64; i++) mem[i] = int'($urandom_range(0, 900)) - 300;
    endtask

    task automatic run_block(output int e0);
        int n;
        clear_mon();
        step();
        Start = 1'b1;
        e0 = cyc + 1;
        step();
        Start = 1'b0;
        n = 0;
        while (done_cyc.size() == 0 && n < 60) begin step(); n++; end
        step();
    endtask

    task automatic check_block(input int blk, input int e0, input string name);
        int ea, ed;
        tests++;
        if (wr_addr.size() != 32 || done_cyc.size() != 1) begin
            fails++;
            $display("FAIL %s blk %0d: writes=%0d dones=%0d, required 32 and 1", name, blk, wr_addr.size(), done_cyc.size());
        end else if (done_cyc[0] != e0 + 34) begin
            fails++;
            $display("FAIL %s blk %0d done cycle: got E0+%0d, required E0+34", name, blk, done_cyc[0] - e0);
        end else begin
            for (int k = 0; k < 32; k++) begin
                ea = exp_addr(blk, k);
                ed = exp_byte(mem[2 * k]) * 256 + exp_byte(mem[2 * k + 1]);
                if (wr_addr[k] != ea || wr_data[k] != ed || wr_cyc[k] != e0 + 2 + k) begin
                    fails++;
                    $display("FAIL %s blk %0d k=%0d: addr %0d data %h cyc E0+%0d, required addr %0d data %h cyc E0+%0d",
                             name, blk, k, wr_addr[k], wr_data[k], wr_cyc[k] - e0, ea, ed, 2 + k);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Start = 1'b1;
        clear_mon();
        repeat (5) step();
        tests++;
        if (SRAM_we_n !== 1'b1 || Done !== 1'b0 || All_done !== 1'b0 || SRAM_address !== 18'd0 ||
            SRAM_write_data !== 16'd0 || DP_address_a !== 6'd0 || DP_address_b !== 6'd1 || wr_addr.size() != 0) begin
            fails++;
            $display("FAIL reset_values: we_n=%b done=%b all=%b addr=%0d wd=%h dpa=%0d dpb=%0d writes=%0d, required 1 0 0 0 0000 0 1 0",
                     SRAM_we_n, Done, All_done, SRAM_address, SRAM_write_data, DP_address_a, DP_address_b, wr_addr.size());
        end
        Start = 1'b0;
        Resetn = 1'b1;
        repeat (10) step();
        tests++;
        if (wr_addr.size() != 0 || done_cyc.size() != 0) begin
            fails++;
            $display("FAIL reset_idle: writes=%0d dones=%0d, required 0 0", wr_addr.size(), done_cyc.size());
        end
    endtask

    task automatic test_block0();
        int e0;
        for (int i = 0; i < 64; i++) mem[i] = i;
        run_block(e0);
        check_block(0, e0, "block0");
        tests++;
        if (wr_addr.size() != 32 || wr_addr[0] != 0 || wr_data[0] != 'h0001 || wr_addr[3] != 3 || wr_data[3] != 'h0607 ||
            wr_addr[4] != 160 || wr_data[4] != 'h0809 || wr_addr[15] != 483 || wr_data[15] != 'h1E1F) begin
            fails++;
            $display("FAIL block0_words: size=%0d, required addr0=0001 addr3=0607 addr160=0809 addr483=1E1F", wr_addr.size());
        end
    endtask

    task automatic test_clip();
        int e0, req;
`ifdef M2_WRITE_CLIP_EN
        req = 'h00FF;
`else
        req = 'hFB2C;
`endif
        randomize_mem();
        mem[0] = -5;
        mem[1] = 300;
        run_block(e0);
        check_block(1, e0, "clip");
        tests++;
        if (wr_addr.size() == 0 || wr_addr[0] != 4 || wr_data[0] != req) begin
            fails++;
            $display("FAIL clip_word: addr %0d data %h, required addr 4 data %h",
                     wr_addr.size() ? wr_addr[0] : -1, wr_data.size() ? wr_data[0] : -1, req);
        end
    endtask

    task automatic test_start_during_write();
        int e0, n;
        randomize_mem();
        clear_mon();
        step();
        Start = 1'b1;
        e0 = cyc + 1;
        step();
        Start = 1'b0;
        repeat (8) step();
        Start = 1'b1;
        step();
        Start = 1'b0;
        n = 0;
        while (done_cyc.size() == 0 && n < 60) begin step(); n++; end
        repeat (40) step();
        check_block(2, e0, "start_in_write");
    endtask

    task automatic test_advance();
        int e0;
        int first_req [int];
        first_req[40] = 1280; first_req[1200] = 38400; first_req[1220] = 39040; first_req[1800] = 57600;
        for (int b = 3; b < 2400; b++) begin
            randomize_mem();
            run_block(e0);
            check_block(b, e0, "advance");
            if (first_req.exists(b)) begin
                tests++;
                if (wr_addr.size() == 0 || wr_addr[0] != first_req[b]) begin
                    fails++;
                    $display("FAIL first_addr blk %0d: got %0d, required %0d", b, wr_addr.size() ? wr_addr[0] : -1, first_req[b]);
                end
            end
            if (b == 2398) begin
                tests++;
                if (All_done !== 1'b0 || done_ad.size() != 1 || done_ad[0] != 0) begin
                    fails++;
                    $display("FAIL all_done_early: All_done=%b, required 0 before block 2399", All_done);
                end
            end
        end
        tests++;
        if (wr_addr.size() != 32 || wr_addr[31] != 76799 || done_ad.size() != 1 || done_ad[0] != 1 || All_done !== 1'b1) begin
            fails++;
            $display("FAIL last_block: final addr %0d all_done_at_done %0d, required 76799 and 1",
                     wr_addr.size() ? wr_addr[wr_addr.size() - 1] : -1, done_ad.size() ? done_ad[0] : -1);
        end
    endtask

    task automatic test_after_all_done();
        int e0;
        run_block(e0);
        tests++;
        if (wr_addr.size() != 0 || done_cyc.size() != 0 || All_done !== 1'b1) begin
            fails++;
            $display("FAIL after_all_done: writes=%0d dones=%0d all=%b, required 0 0 1", wr_addr.size(), done_cyc.size(), All_done);
        end
    endtask

    task automatic test_reset_midblock();
        int e0, n;
        Resetn = 1'b0;
        repeat (2) step();
        Resetn = 1'b1;
        step();
        randomize_mem();
        clear_mon();
        Start = 1'b1;
        step();
        Start = 1'b0;
        n = 0;
        while (wr_addr.size() < 11 && n < 40) begin step(); n++; end
        Resetn = 1'b0;
        #1;
        tests++;
        if (wr_addr.size() != 11 || SRAM_we_n !== 1'b1 || SRAM_address !== 18'd0) begin
            fails++;
            $display("FAIL reset_midblock: writes_seen=%0d we_n=%b addr=%0d, required 11 1 0", wr_addr.size(), SRAM_we_n, SRAM_address);
        end
        repeat (3) step();
        Resetn = 1'b1;
        step();
        randomize_mem();
        run_block(e0);
        check_block(0, e0, "rewrite_block0");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 0;
        test_reset();
        test_block0();
        test_clip();
        test_start_during_write();
        test_advance();
        test_after_all_done();
        test_reset_midblock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
